// File: rtl/mem_lsu_pkg.sv
// Shared constants and helpers for the load/store controller.
package mem_lsu_pkg;

  // funct3 encodings for the supported access types
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM encoding
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE  = 2'd0;
  localparam lsu_state_t ST_WRITE = 2'd1;
  localparam lsu_state_t ST_READ  = 2'd2;
  localparam lsu_state_t ST_RESP  = 2'd3;

  // Byte enables for an access size (funct3[1:0]: 0 byte, 1 half, else word)
  function automatic logic [3:0] size_be(input logic [1:0] size);
    case (size)
      2'b00:   size_be = 4'b0001;
      2'b01:   size_be = 4'b0011;
      default: size_be = 4'b1111;
    endcase
  endfunction

  // Offset of the last byte touched by an access of the given size
  function automatic logic [1:0] size_last_off(input logic [1:0] size);
    case (size)
      2'b00:   size_last_off = 2'd0;
      2'b01:   size_last_off = 2'd1;
      default: size_last_off = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational access decode: byte enables, lane-aligned store data,
// size-extended load data and the request error flag.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ALIGN_CHK = 1
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] last_byte;

  // Error classification; the last-byte sum is 33 bits so it cannot wrap
  always_comb begin
    illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
    last_byte    = {1'b0, addr} + {31'b0, size_last_off(funct3[1:0])};
    out_of_range = (last_byte >> ADDR_W) != 33'd0;
    misaligned   = 1'b0;
    if (ALIGN_CHK != 0) begin
      case (funct3[1:0])
        2'b01:   misaligned = addr[0];
        2'b10:   misaligned = (addr[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
    err = illegal || out_of_range || misaligned;
  end

  // Byte enables and store data, right-justified into lane 0 upward
  always_comb begin
    be = size_be(funct3[1:0]);
    case (funct3[1:0])
      2'b00:   wdata_al = {24'b0, wdata[7:0]};
      2'b01:   wdata_al = {16'b0, wdata[15:0]};
      default: wdata_al = wdata;
    endcase
  end

  // Load extension by access type
  always_comb begin
    case (funct3)
      F3_B:    rdata_ext = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   rdata_ext = {24'b0, rdata[7:0]};
      F3_H:    rdata_ext = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   rdata_ext = {16'b0, rdata[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Load/store controller: one request at a time, registered memory strobes,
// registered response with error flag and saturating error counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | req_ready=1; accept, decode, launch the memory strobes
//   ST_WRITE | mem_write asserted for this single cycle
//   ST_READ  | mem_addr driven; extended mem_rdata captured at cycle end
//   ST_RESP  | resp_valid=1, held until resp_ready
module mem_lsu_ctrl
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ALIGN_CHK = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [3:0]           mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  lsu_state_t  state;
  lsu_state_t  state_nxt;
  logic [2:0]  lat_f3;
  logic [2:0]  al_f3;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_err;
  logic        accept;

  // In IDLE the decoder looks at the live request; afterwards the latched
  // funct3 selects the load extension during READ.
  assign al_f3      = (state == ST_IDLE) ? req_funct3 : lat_f3;
  assign accept     = (state == ST_IDLE) && req_valid;
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  mem_lsu_align #(
    .ADDR_W    (ADDR_W),
    .ALIGN_CHK (ALIGN_CHK)
  ) u_align (
    .we        (req_we),
    .funct3    (al_f3),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_al  (al_wdata),
    .rdata_ext (al_rdata),
    .err       (al_err)
  );

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (al_err)      state_nxt = ST_RESP;
          else if (req_we) state_nxt = ST_WRITE;
          else             state_nxt = ST_READ;
        end
      end
      ST_WRITE: state_nxt = ST_RESP;
      ST_READ:  state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Latch the access type for load extension
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lat_f3 <= F3_B;
    else if (accept) lat_f3 <= req_funct3;
  end

  // Memory strobes: launched at acceptance so they are stable for the whole
  // WRITE/READ cycle; an erroring request never touches memory. The async
  // reset on mem_write kills a write that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_write <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'b0;
    end else begin
      if (accept && !al_err) begin
        mem_addr <= req_addr[ADDR_W-1:0];
        if (req_we) begin
          mem_write <= al_be;
          mem_wdata <= al_wdata;
        end
      end
      if (state == ST_WRITE) mem_write <= 4'b0000;
    end
  end

  // Response register: cleared at acceptance, load data captured in READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        resp_rdata <= 32'b0;
        resp_err   <= al_err;
      end
      if (state == ST_READ) resp_rdata <= al_rdata;
    end
  end

  // Saturating error counter, bumped on the IDLE->RESP error transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && al_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Scoreboard bench for mem_lsu_ctrl with a byte-addressed memory model.
module tb_mem_lsu_ctrl;
  import mem_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  err_cnt;

  mem_lsu_ctrl #(.ADDR_W(16), .ALIGN_CHK(1), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read of addr..addr+3, byte-lane writes on posedge
  logic [7:0] mem [0:65535];
  assign mem_rdata = {mem[mem_addr + 16'd3], mem[mem_addr + 16'd2],
                      mem[mem_addr + 16'd1], mem[mem_addr]};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_write[i]) mem[mem_addr + 16'(i)] <= mem_wdata[8*i +: 8];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  // Count write cycles seen on the memory port
  int wr_count = 0;
  always @(negedge clk) begin
    if (mem_write != 4'b0000) wr_count <= wr_count + 1;
  end

  // Scoreboard
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        fail_timeout("resp_unexpected");
      end else begin
        got = sb.pop_front();
        chk("resp_err",   32'(resp_err), 32'(got.err));
        chk("resp_rdata", resp_rdata,    got.rdata);
      end
    end
  end

  // Issue one request, expect a response, and check the cycle-level timing
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    exp_t e;
    bit   acc;
    e.err   = exp_err;
    e.rdata = exp_rd;
    sb.push_back(e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (req_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      fail_timeout("req_accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (exp_err) begin
      chk("err_path_valid",   32'(resp_valid), 32'd1);
      chk("err_path_nowrite", 32'(mem_write),  32'd0);
    end else begin
      chk("mem_cycle_be",    32'(mem_write),  we ? 32'(exp_be) : 32'd0);
      chk("mem_cycle_addr",  32'(mem_addr),   32'(addr[15:0]));
      chk("mem_cycle_valid", 32'(resp_valid), 32'd0);
      if (we) chk("mem_cycle_wdata", mem_wdata, exp_wd);
      @(negedge clk);
      chk("resp_latency", 32'(resp_valid), 32'd1);
      chk("resp_nowrite", 32'(mem_write),  32'd0);
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) done = 1'b1;
    end
    if (!done) fail_timeout("resp_drain");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_mem_write"},  32'(mem_write),  32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    chk({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    logic [7:0] snap [4];
    bit acc;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // 1: word store
    do_req(1'b1, F3_W, 32'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
    wait_done();
    chk("sw_wr_count", 32'(wr_count), 32'd1);
    chk("sw_mem_b0", 32'(mem[16'h0010]), 32'hEF);
    chk("sw_mem_b3", 32'(mem[16'h0013]), 32'hDE);

    // 2: byte store then loads of every flavour
    do_req(1'b1, F3_B,  32'h0013, 32'h12345680, 1'b0, 32'h0,        4'b0001, 32'h00000080);
    wait_done();
    do_req(1'b0, F3_B,  32'h0013, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b0, F3_BU, 32'h0013, 32'h0,        1'b0, 32'h00000080, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b0, F3_W,  32'h0010, 32'h0,        1'b0, 32'h80ADBEEF, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b0, F3_H,  32'h0012, 32'h0,        1'b0, 32'hFFFF80AD, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b0, F3_HU, 32'h0012, 32'h0,        1'b0, 32'h000080AD, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b1, F3_H,  32'h0020, 32'hAAAA1234, 1'b0, 32'h0,        4'b0011, 32'h00001234);
    wait_done();
    do_req(1'b0, F3_W,  32'h0020, 32'h0,        1'b0, 32'h00001234, 4'b0000, 32'h0);
    wait_done();
    chk("no_err_cnt", 32'(err_cnt), 32'd0);

    // 3: misaligned, range errors and the top-byte boundary
    do_req(1'b0, F3_H, 32'h0011, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    wait_done();
    chk("misalign_err_cnt", 32'(err_cnt), 32'd1);
    do_req(1'b1, F3_W, 32'hFFFE, 32'h55555555, 1'b1, 32'h0, 4'b0000, 32'h0);
    wait_done();
    chk("range_err_cnt", 32'(err_cnt), 32'd2);
    do_req(1'b0, F3_W, 32'h0001_0000, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    wait_done();
    chk("upper_err_cnt", 32'(err_cnt), 32'd3);
    do_req(1'b1, F3_B,  32'hFFFF, 32'h0000007F, 1'b0, 32'h0,        4'b0001, 32'h0000007F);
    wait_done();
    do_req(1'b0, F3_BU, 32'hFFFF, 32'h0,        1'b0, 32'h0000007F, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b0, F3_H,  32'hFFFE, 32'h0,        1'b0, 32'h00007F00, 4'b0000, 32'h0);
    wait_done();
    chk("boundary_err_cnt", 32'(err_cnt), 32'd3);
    chk("total_writes", 32'(wr_count), 32'd4);

    // 4: response back-pressure
    resp_ready = 1'b0;
    do_req(1'b0, F3_W, 32'h0010, 32'h0, 1'b0, 32'h80ADBEEF, 4'b0000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid",     32'(resp_valid), 32'd1);
      chk("hold_rdata",     resp_rdata,      32'h80ADBEEF);
      chk("hold_req_ready", 32'(req_ready),  32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_idle", 32'(req_ready), 32'd1);
    chk("release_drained", 32'(sb.size()), 32'd0);

    // 5: reset during a word store
    for (int i = 0; i < 4; i++) snap[i] = mem[16'h0020 + 16'(i)];
    wc = wr_count;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h0020;
    req_wdata  = 32'h11223344;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (req_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) fail_timeout("rst_req_accept");
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rst_write_be", 32'(mem_write), 32'hF);
    #1 rst_n = 1'b0;
    #1 chk("rst_write_killed", 32'(mem_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("rst_mem_kept", 32'(mem[16'h0020 + 16'(i)]), 32'(snap[i]));
    chk("rst_wr_count", 32'(wr_count), 32'(wc));
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    do_req(1'b0, F3_W, 32'h0020, 32'h0, 1'b0, 32'h00001234, 4'b0000, 32'h0);
    wait_done();

    // 6: illegal funct3 and counter saturation
    do_req(1'b0, 3'b011, 32'h0010, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b1, F3_BU,  32'h0010, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    wait_done();
    chk("illegal_err_cnt", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 253; i++) begin
      do_req(1'b0, 3'b110, 32'h0010, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
      wait_done();
    end
    chk("err_cnt_255", 32'(err_cnt), 32'hFF);
    do_req(1'b0, 3'b111, 32'h0010, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    wait_done();
    do_req(1'b1, F3_HU,  32'h0010, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    wait_done();
    chk("err_cnt_saturated", 32'(err_cnt), 32'hFF);
    chk("final_writes", 32'(wr_count), 32'd4);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
